register_scoreboard: RTL
========================

# register_scoreboard

Register file plus per-register pending-write scoreboard for the decode stage. It supplies the two combinational read ports that decode consumes: `register_read_N`, `register_read_N_data` and `register_read_N_contended`. It records each issued instruction's destination register, and clears that record when the result is written back or the instruction is squashed. Decode stalls on contended operands and observes `issue_ready` before handing an instruction forward.

## Interface
- `DATA_WIDTH`, default 32: register width.
- `NUM_REGISTERS`, default 32: architectural registers; index 0 is hardwired zero.
- `REGISTER_INDEXING_WIDTH`, default $clog2(NUM_REGISTERS): register index width.
- `MAX_PENDING`, default 3: maximum outstanding writes per register.
- `PENDING_WIDTH`, default $clog2(MAX_PENDING+1): per-register counter width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `register_read_1`  in  REGISTER_INDEXING_WIDTH  read port 1 index.
- `register_read_1_data`  out  DATA_WIDTH  read port 1 value.
- `register_read_1_contended`  out  1  read port 1 value is not yet final.
- `register_read_2`, `register_read_2_data`, `register_read_2_contended`: same as port 1, for port 2.
- `issue_valid`  in  1  an instruction with a destination register transfers out of decode this cycle.
- `issue_register`  in  REGISTER_INDEXING_WIDTH  destination of the issuing instruction.
- `issue_ready`  out  1  `issue_register` counter is below MAX_PENDING.
- `writeback_valid`  in  1  result write this cycle.
- `writeback_register`  in  REGISTER_INDEXING_WIDTH  result destination.
- `writeback_data`  in  DATA_WIDTH  result value.
- `squash_valid`  in  1  an issued instruction is cancelled without writing.
- `squash_register`  in  REGISTER_INDEXING_WIDTH  destination of the cancelled instruction.
- `underflow_error`  out  1  sticky flag: a retire arrived for a register with counter 0.

## Operation
- **State:**
  - `regs[1..NUM_REGISTERS-1]`, DATA_WIDTH each.
  - `pending[1..NUM_REGISTERS-1]`, PENDING_WIDTH each.
  - `underflow_error` flag.
  - Index 0 has no state. It reads 0, is never contended, and all events targeting it are ignored.
- **Reset** (`rst`=1 at posedge):
  - all regs cleared to 0, all pending cleared to 0, `underflow_error` cleared to 0.
  - Applies regardless of simultaneous issue, writeback or squash, which are all dropped.
  - Combinational outputs after reset: data 0, contended 0, `issue_ready` 1.
- **Counter update**, per register r≠0, each cycle:
  - delta = +1 if issue hits r, −1 if writeback hits r, −1 if squash hits r.
  - All three may hit the same r in one cycle; the net delta is applied.
  - Result is clamped to [0, MAX_PENDING].
  - If the unclamped result is below 0, `underflow_error` is set and the counter becomes 0.
  - An issue arriving while the counter is at MAX_PENDING (`issue_ready`=0) is a protocol violation. The counter saturates, with no error flagged.
- **Register write:**
  - `writeback_valid` with r≠0 writes `writeback_data` into `regs[r]` at posedge.
  - The write happens regardless of the counter value.
- **Read port N**, combinational:
  - hit = `writeback_valid` and `writeback_register`==`register_read_N` and index≠0.
  - data = 0 for index 0; else `writeback_data` if hit; else `regs[index]`.
  - contended = (`pending[index]` − hit − squash hit) > 0, evaluated with unclamped arithmetic.
- **No combinational dependency on issue:**
  - Contended and data do not depend on `issue_valid` or `issue_register`, because decode's issue depends on contended.
  - An instruction that reads and writes the same register sees the pre-issue state.
- **`issue_ready`** = (`issue_register`==0) or (`pending[issue_register]` < MAX_PENDING). It is independent of `issue_valid`.

## Timing
- Read latency is 0 cycles (combinational).
- Writeback is bypassed to the reads in the same cycle.
- Issue takes effect on contended starting the cycle after the issue posedge.
- Squash and writeback release contention in the same cycle they are asserted.
- `underflow_error` asserts the cycle after the offending event and holds until reset.
- No internal pipeline; no output depends on more than one cycle of history beyond the stored state.

## Test plan
- **Reset:** write x5=0xDEAD, then assert `rst`. Read x5 → data 0, contended 0, `issue_ready` 1, `underflow_error` 0.
- **Issue then writeback:**
  - Issue x7 at cycle 0 → x7 contended from cycle 1.
  - Writeback x7=0x1234 at cycle 3 → that cycle, port 1 reads x7 with data 0x1234 and contended 0.
  - From cycle 4: `regs` holds 0x1234, contended 0.
- **Counter saturation:**
  - Issue x3 three times → `issue_ready` 0 for x3; x4 still shows `issue_ready` 1.
  - One writeback x3 → `issue_ready` 1 and contended still 1.
  - Two more retires → contended 0.
- **Simultaneous events:**
  - With pending[9]=1: issue x9 together with writeback x9=0x55 → data 0x55 and contended 0 that cycle; contended 1 the next cycle (count stays 1).
  - Squash x9 → contended 0 that cycle.
- **x0 and errors:**
  - Issue/writeback x0=0xFF → x0 reads 0, contended 0.
  - Squash x12 with pending 0 → `underflow_error` 1 next cycle, held until reset; pending[12] stays 0.

Source files
------------

// File: rtl/register_scoreboard.sv
// register_scoreboard
//
// Register file with a per-register count of outstanding (issued but not yet
// retired) writes. Decode reads operands through two combinational ports and
// stalls while an operand is contended; it issues only while issue_ready is high.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   register_read_N              read port N index (N = 1, 2)
//   register_read_N_data         read port N value, writeback bypassed
//   register_read_N_contended    read port N value still has a write in flight
//   issue_valid/issue_register   destination of an instruction leaving decode
//   issue_ready                  destination counter is below MAX_PENDING
//   writeback_valid/_register/_data  result write
//   squash_valid/squash_register     cancelled instruction's destination
//   underflow_error              sticky: a retire hit a register with count 0

module register_scoreboard #(
    parameter int DATA_WIDTH              = 32,
    parameter int NUM_REGISTERS           = 32,
    parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
    parameter int MAX_PENDING             = 3,
    parameter int PENDING_WIDTH           = $clog2(MAX_PENDING + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] register_read_1,
    output logic [DATA_WIDTH-1:0]              register_read_1_data,
    output logic                               register_read_1_contended,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] register_read_2,
    output logic [DATA_WIDTH-1:0]              register_read_2_data,
    output logic                               register_read_2_contended,
    input  logic                               issue_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_register,
    output logic                               issue_ready,
    input  logic                               writeback_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] writeback_register,
    input  logic [DATA_WIDTH-1:0]              writeback_data,
    input  logic                               squash_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] squash_register,
    output logic                               underflow_error
);

    // Two extra bits: one for the +1 headroom, one for the sign.
    typedef logic signed [PENDING_WIDTH+1:0] sum_t;

    localparam logic [REGISTER_INDEXING_WIDTH-1:0] ZERO_INDEX = '0;
    localparam logic [PENDING_WIDTH-1:0] PENDING_MAX = PENDING_WIDTH'(MAX_PENDING);

    // Entry 0 is only ever loaded by reset, so it stays a constant zero.
    logic [DATA_WIDTH-1:0]    regs    [NUM_REGISTERS];
    logic [PENDING_WIDTH-1:0] pending [NUM_REGISTERS];

    logic [PENDING_WIDTH-1:0] pending_next [NUM_REGISTERS];
    logic                     any_underflow;

    // Net counter delta per register. Issue, writeback and squash may all land
    // on the same register; the sum is clamped, and going below zero is flagged.
    always_comb begin
        sum_t sum;
        logic issue_hit;
        logic wb_hit;
        logic sq_hit;
        sum           = '0;
        issue_hit     = 1'b0;
        wb_hit        = 1'b0;
        sq_hit        = 1'b0;
        any_underflow = 1'b0;
        pending_next[0] = '0;
        for (int r = 1; r < NUM_REGISTERS; r++) begin
            issue_hit = issue_valid     && (issue_register     == REGISTER_INDEXING_WIDTH'(r));
            wb_hit    = writeback_valid && (writeback_register == REGISTER_INDEXING_WIDTH'(r));
            sq_hit    = squash_valid    && (squash_register    == REGISTER_INDEXING_WIDTH'(r));
            sum = sum_t'({2'b00, pending[r]}) + sum_t'(issue_hit)
                  - sum_t'(wb_hit) - sum_t'(sq_hit);
            if (sum < sum_t'(0)) begin
                pending_next[r] = '0;
                any_underflow   = 1'b1;
            end else if (sum > sum_t'(MAX_PENDING)) begin
                // Issue while already full: saturate silently.
                pending_next[r] = PENDING_MAX;
            end else begin
                pending_next[r] = sum[PENDING_WIDTH-1:0];
            end
        end
    end

    // State update. Reset wins over every event arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                regs[r]    <= '0;
                pending[r] <= '0;
            end
            underflow_error <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGISTERS; r++) begin
                pending[r] <= pending_next[r];
            end
            if (writeback_valid && (writeback_register != ZERO_INDEX)) begin
                regs[writeback_register] <= writeback_data;
            end
            underflow_error <= underflow_error | any_underflow;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_data(
        input logic [REGISTER_INDEXING_WIDTH-1:0] index
    );
        if (index == ZERO_INDEX) begin
            return '0;
        end else if (writeback_valid && (writeback_register == index)) begin
            return writeback_data;
        end else begin
            return regs[index];
        end
    endfunction

    // A writeback or squash landing this cycle already releases the operand,
    // so subtract them before testing. Issue is deliberately not involved.
    function automatic logic read_contended(
        input logic [REGISTER_INDEXING_WIDTH-1:0] index
    );
        sum_t remaining;
        logic wb_hit;
        logic sq_hit;
        if (index == ZERO_INDEX) begin
            return 1'b0;
        end
        wb_hit    = writeback_valid && (writeback_register == index);
        sq_hit    = squash_valid    && (squash_register    == index);
        remaining = sum_t'({2'b00, pending[index]}) - sum_t'(wb_hit) - sum_t'(sq_hit);
        return remaining > sum_t'(0);
    endfunction

    always_comb begin
        register_read_1_data      = read_data(register_read_1);
        register_read_1_contended = read_contended(register_read_1);
        register_read_2_data      = read_data(register_read_2);
        register_read_2_contended = read_contended(register_read_2);
        issue_ready = (issue_register == ZERO_INDEX) || (pending[issue_register] < PENDING_MAX);
    end

endmodule
